// File: rtl/digital_qam_modulation_pkg.sv
// Shared types and constants for the 16-QAM test-source modulator:
// signed level type, Gray level table, offset code and default PRBS seed.
package qam_pkg;

  typedef logic signed [2:0] level_t;

  localparam logic [2:0]  OFFSET       = 3'd4;
  localparam logic [14:0] DEFAULT_SEED = 15'h0001;

  // Gray-coded dibit to amplitude level: 00,01,11,10 -> -3,-1,+1,+3
  function automatic level_t gray_level(input logic [1:0] b);
    case (b)
      2'b00:   return level_t'(-3);
      2'b01:   return level_t'(-1);
      2'b11:   return level_t'(1);
      default: return level_t'(3);
    endcase
  endfunction

endpackage

// File: rtl/digital_qam_modulation_prbs_lfsr15.sv
// 15-bit Fibonacci PRBS (x^15+x^14+1) that jumps four steps per advance;
// exposes the low nibble of the post-jump state as the next symbol.
module prbs_lfsr15 #(
  parameter logic [14:0] SEED = 15'h0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv,
  output logic [3:0] nib
);

  // An all-zero seed would lock the register up, so it is substituted.
  localparam logic [14:0] SEED_EFF = (SEED == 15'd0) ? 15'h0001 : SEED;

  logic [14:0] state;

  function automatic logic [14:0] step(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      state <= SEED_EFF;
    else if (adv) state <= step(step(step(step(state))));
  end

  assign nib = state[3:0];

endmodule

// File: rtl/digital_qam_modulation.sv
// 16-QAM modulator test source: PRBS symbols, Gray mapping, 4-phase carrier
// mixing, offset-coded 3-bit sample output plus divided sample clock and symbol strobe.
module digital_qam_modulation
  import qam_pkg::*;
#(
  parameter int          HALF_DIV   = 4,
  parameter int          SYM_CYCLES = 2,
  parameter logic [14:0] LFSR_SEED  = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst,
  output logic       clk_m,
  output logic       m_align,
  output logic [2:0] A_reg
);

  localparam int DIV_N  = 2 * HALF_DIV;
  localparam int DIV_W  = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam int SAMP_N = 4 * SYM_CYCLES;
  localparam int SAMP_W = $clog2(SAMP_N);

  logic [DIV_W-1:0]  div_cnt, div_cnt_next;
  logic [SAMP_W-1:0] samp_idx;
  logic              tick, sym_start;
  logic [3:0]        lfsr_nib;
  level_t            i_lvl_p0, q_lvl_p0;
  level_t            cur_i, cur_q, samp;

  function automatic logic [2:0] to_offset(input level_t s);
    return 3'(s) + OFFSET;
  endfunction

  prbs_lfsr15 #(.SEED(LFSR_SEED)) u_prbs (
    .clk (clk),
    .rst (rst),
    .adv (sym_start),
    .nib (lfsr_nib)
  );

  always_comb begin
    div_cnt_next = (div_cnt == DIV_W'(DIV_N - 1)) ? '0 : div_cnt + 1'b1;
    tick         = (div_cnt_next == DIV_W'(HALF_DIV));
    sym_start    = tick && (samp_idx == '0);
  end

  // The symbol-start sample uses the fresh PRBS nibble before it is latched.
  always_comb begin
    cur_i = sym_start ? gray_level(lfsr_nib[3:2]) : i_lvl_p0;
    cur_q = sym_start ? gray_level(lfsr_nib[1:0]) : q_lvl_p0;
    case (samp_idx[1:0])
      2'd0:    samp = cur_i;
      2'd1:    samp = cur_q;
      2'd2:    samp = -cur_i;
      default: samp = -cur_q;
    endcase
  end

  // Stage p0: divider, sample counter and symbol latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      samp_idx <= '0;
      i_lvl_p0 <= '0;
      q_lvl_p0 <= '0;
    end else begin
      div_cnt <= div_cnt_next;
      if (tick)
        samp_idx <= (samp_idx == SAMP_W'(SAMP_N - 1)) ? '0 : samp_idx + 1'b1;
      if (sym_start) begin
        i_lvl_p0 <= cur_i;
        q_lvl_p0 <= cur_q;
      end
    end
  end

  // Stage p1: registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_m   <= 1'b0;
      m_align <= 1'b0;
      A_reg   <= OFFSET;
    end else begin
      clk_m   <= (div_cnt_next >= DIV_W'(HALF_DIV));
      m_align <= sym_start;
      if (tick)
        A_reg <= to_offset(samp);
    end
  end

endmodule

// File: tb/tb_digital_qam_modulation.sv
// Scoreboard bench for digital_qam_modulation (default parameters) and its PRBS sub-module.
module tb_digital_qam_modulation;

  localparam int HD      = 4;
  localparam int SC      = 2;
  localparam int PER     = 2 * HD;
  localparam int SYM_CLK = PER * 4 * SC;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_m, m_align;
  logic [2:0] A_reg;

  logic       prst = 1'b1;
  logic       padv = 1'b0;
  logic [3:0] pnib;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int clk_m;
    int m_align;
    int a;
  } exp_t;

  exp_t     sb[$];
  logic [3:0] syms[64];

  always #5 clk = ~clk;

  digital_qam_modulation dut (
    .clk     (clk),
    .rst     (rst),
    .clk_m   (clk_m),
    .m_align (m_align),
    .A_reg   (A_reg)
  );

  prbs_lfsr15 #(.SEED(15'h0001)) u_prbs (
    .clk (clk),
    .rst (prst),
    .adv (padv),
    .nib (pnib)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lvl(input logic [1:0] b);
    case (b)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  // Expected outputs after the n-th rising edge following reset release.
  function automatic exp_t model(input int n);
    exp_t e;
    int idx, p, i, q, s;
    logic [3:0] sym;
    e.clk_m   = ((n % PER) >= HD) ? 1 : 0;
    e.m_align = ((n % SYM_CLK) == HD) ? 1 : 0;
    if (n < HD) begin
      e.a = 4;
    end else begin
      idx = (n - HD) / PER;
      sym = syms[idx / (4 * SC)];
      p   = idx % 4;
      i   = lvl(sym[3:2]);
      q   = lvl(sym[1:0]);
      case (p)
        0:       s = i;
        1:       s = q;
        2:       s = -i;
        default: s = -q;
      endcase
      e.a = s + 4;
    end
    return e;
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_clk_m"}, {31'd0, clk_m}, 0);
    chk({tag, "_m_align"}, {31'd0, m_align}, 0);
    chk({tag, "_A_reg"}, {29'd0, A_reg}, 4);
  endtask

  task automatic run_cycles(input int ncyc, input string tag, output int pulses,
                            output int first_p, output int second_p);
    exp_t e;
    pulses   = 0;
    first_p  = -1;
    second_p = -1;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge clk);
      sb.push_back(model(k));
      @(negedge clk);
      e = sb.pop_front();
      chk({tag, "_clk_m"}, {31'd0, clk_m}, e.clk_m);
      chk({tag, "_m_align"}, {31'd0, m_align}, e.m_align);
      chk({tag, "_A_reg"}, {29'd0, A_reg}, e.a);
      if (m_align === 1'b1) begin
        pulses++;
        if (first_p < 0) first_p = k;
        else if (second_p < 0) second_p = k;
      end
    end
  endtask

  initial begin
    logic [14:0] l;
    int pulses, fp, spk, period, exp_pulses;
    bit zero_seen;

    l = 15'h0001;
    for (int i = 0; i < 64; i++) begin
      syms[i] = l[3:0];
      repeat (4) l = {l[13:0], l[14] ^ l[13]};
    end

    rst = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check_reset_vals("hold");
    end
    chk("prbs_rst_state", {17'd0, u_prbs.state}, 32'h1);

    // Run into symbol 1, then hit it with a mid-symbol reset.
    rst = 1'b0;
    run_cycles(SYM_CLK + 20, "run0", pulses, fp, spk);
    chk("first_align_edge", fp, HD);
    rst = 1'b1;
    #1;
    check_reset_vals("async");
    repeat (3) begin
      @(negedge clk);
      check_reset_vals("midrst");
    end
    rst = 1'b0;

    run_cycles(20 * SYM_CLK, "run1", pulses, fp, spk);
    exp_pulses = 0;
    for (int n = 1; n <= 20 * SYM_CLK; n++)
      if (n % SYM_CLK == HD) exp_pulses++;
    chk("align_count", pulses, exp_pulses);
    chk("align_gap", spk - fp, SYM_CLK);

    // Full-period PRBS check on the stand-alone generator.
    @(negedge clk);
    prst      = 1'b0;
    padv      = 1'b1;
    period    = 0;
    zero_seen = 1'b0;
    for (int k = 1; k <= 40000; k++) begin
      @(negedge clk);
      if (u_prbs.state == 15'd0) zero_seen = 1'b1;
      if (u_prbs.state == 15'h0001) begin
        period = k;
        break;
      end
    end
    chk("prbs_period", period, 32767);
    chk("prbs_no_zero", {31'd0, zero_seen}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
